i2c_seg_regs: RTL and testbench

I2C_SEG_REGS -- requirements
Module: i2c_seg_regs

---
 rtl/i2c_seg_regs.sv | 189 ++++++++++++++++++
 tb/tb_i2c_seg_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_seg_regs.sv
// I2C write-only slave holding a shadow of four hex digits plus decimal points;
// the shadow is committed to the seven-segment outputs atomically on STOP.
`timescale 1ns/1ps
module i2c_seg_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SCL,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic [15:0] D,
    output logic [3:0]  DP,
    output logic        UPDATE
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_PTR      = 3'd3,
        ST_ACK_PTR  = 3'd4,
        ST_DATA     = 3'd5,
        ST_ACK_DATA = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    state_t      state_r, state_s;
    logic        scl_meta_r, scl_sync_r, scl_hist_r;
    logic        sda_meta_r, sda_sync_r, sda_hist_r;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  shift_r, shift_s;
    logic [1:0]  ptr_r, ptr_s;
    logic        sda_oe_r, sda_oe_s;
    logic        dirty_r;
    logic [15:0] shadow_d_r, d_r;
    logic [3:0]  shadow_dp_r, dp_r;
    logic        update_r;
    logic        wr_s, commit_s;
    logic        scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]  byte_s;

    // Bus conditions are derived only from the synchronized and history flops.
    assign scl_rise_s = scl_sync_r & ~scl_hist_r;
    assign scl_fall_s = ~scl_sync_r & scl_hist_r;
    assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
    assign byte_s     = {shift_r[6:0], sda_sync_r};

    assign SDA_OE = sda_oe_r;
    assign D      = d_r;
    assign DP     = dp_r;
    assign UPDATE = update_r;

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, bit framing and ACK control.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        ptr_s     = ptr_r;
        sda_oe_s  = sda_oe_r;
        wr_s      = 1'b0;
        commit_s  = 1'b0;
        if (stop_s) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b0;
            commit_s  = dirty_r;
        end else if (start_s) begin
            state_s   = ST_ADDR;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_DATA: begin
                    if (scl_rise_s) begin
                        shift_s   = byte_s;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            case (state_r)
                                ST_ADDR: begin
                                    if (byte_s[7:1] == SLAVE_ADDR && byte_s[0] == 1'b0) begin
                                        state_s = ST_ACK_ADDR;
                                    end else begin
                                        state_s = ST_IGNORE;
                                    end
                                end
                                ST_PTR: begin
                                    ptr_s   = byte_s[1:0];
                                    state_s = ST_ACK_PTR;
                                end
                                ST_DATA: begin
                                    // Pointer 3 is a dead end: NACK and stay until START/STOP.
                                    if (ptr_r != 2'd3) begin
                                        wr_s    = 1'b1;
                                        ptr_s   = ptr_r + 2'd1;
                                        state_s = ST_ACK_DATA;
                                    end else begin
                                        state_s = ST_DATA;
                                    end
                                end
                                default: state_s = ST_IDLE;
                            endcase
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_DATA: begin
                    // First falling edge drives ACK, second one releases it.
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_s = 1'b1;
                        end else begin
                            sda_oe_s  = 1'b0;
                            bit_cnt_s = 3'd0;
                            state_s   = (state_r == ST_ACK_ADDR) ? ST_PTR : ST_DATA;
                        end
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end
                ST_IDLE, ST_IGNORE: state_s = state_r;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Synchronizers, datapath, shadow registers and atomic commit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_meta_r  <= 1'b1;
            scl_sync_r  <= 1'b1;
            scl_hist_r  <= 1'b1;
            sda_meta_r  <= 1'b1;
            sda_sync_r  <= 1'b1;
            sda_hist_r  <= 1'b1;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            ptr_r       <= 2'd0;
            sda_oe_r    <= 1'b0;
            dirty_r     <= 1'b0;
            shadow_d_r  <= 16'h0000;
            shadow_dp_r <= 4'h0;
            d_r         <= 16'h0000;
            dp_r        <= 4'h0;
            update_r    <= 1'b0;
        end else begin
            scl_meta_r <= SCL;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= SDA_IN;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            ptr_r      <= ptr_s;
            sda_oe_r   <= sda_oe_s;
            update_r   <= commit_s;
            if (wr_s) begin
                case (ptr_r)
                    2'd0:    shadow_d_r[7:0]  <= byte_s;
                    2'd1:    shadow_d_r[15:8] <= byte_s;
                    2'd2:    shadow_dp_r      <= byte_s[3:0];
                    default: shadow_dp_r      <= shadow_dp_r;
                endcase
            end
            if (commit_s) begin
                d_r     <= shadow_d_r;
                dp_r    <= shadow_dp_r;
                dirty_r <= 1'b0;
            end else if (wr_s) begin
                dirty_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_seg_regs.sv
// Bench for i2c_seg_regs: bit-banged I2C master, transaction-level reference
// model, and scoreboard monitors for ACK slots and UPDATE pulses.
`timescale 1ns/1ps
module tb_i2c_seg_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] d;
    logic [3:0]  dp;
    logic        update;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_seg_regs #(.SLAVE_ADDR(7'h3C)) dut (
        .CLK(clk), .RST_N(rst_n), .SCL(scl), .SDA_IN(sda_bus),
        .SDA_OE(sda_oe), .D(d), .DP(dp), .UPDATE(update)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] upd_q[$];
    logic        oe_q[$];
    event        oe_ev;
    logic [19:0] upd_exp;

    // Reference model: register file, pointer, dirty flag, committed outputs.
    logic [7:0]  m_reg [0:2];
    logic        m_dirty;
    logic [1:0]  m_ptr;
    int          m_idx;
    logic        m_sel;
    logic [15:0] m_d;
    logic [3:0]  m_dp;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
        m_dirty = 1'b0; m_ptr = 2'd0; m_idx = 0; m_sel = 1'b0;
        m_d = 16'h0000; m_dp = 4'h0;
        upd_q.delete();
    endtask

    function automatic logic model_byte(logic [7:0] b);
        logic ack;
        if (m_idx == 0) begin
            m_sel = (b == 8'h78);
            ack = m_sel;
        end else if (!m_sel) begin
            ack = 1'b0;
        end else if (m_idx == 1) begin
            m_ptr = b[1:0];
            ack = 1'b1;
        end else if (m_ptr != 2'd3) begin
            m_reg[m_ptr] = b;
            m_ptr = m_ptr + 2'd1;
            m_dirty = 1'b1;
            ack = 1'b1;
        end else begin
            ack = 1'b0;
        end
        m_idx++;
        return ack;
    endfunction

    task automatic send_bit(logic v, logic exp_oe);
        #50 sda_m = v;
        #50 scl = 1'b1;
        #50 oe_q.push_back(exp_oe);
        -> oe_ev;
        #50 scl = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        logic ack;
        ack = model_byte(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        send_bit(1'b1, ack);
    endtask

    task automatic send_partial(logic [7:0] b, int n);
        for (int i = 0; i < n; i++) send_bit(b[7-i], 1'b0);
    endtask

    task automatic i2c_start();
        m_idx = 0; m_sel = 1'b0;
        #50 sda_m = 1'b1;
        #50 scl = 1'b1;
        #50 sda_m = 1'b0;
        #50 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #50 sda_m = 1'b0;
        #50 scl = 1'b1;
        if (m_dirty) begin
            m_d = {m_reg[1], m_reg[0]};
            m_dp = m_reg[2][3:0];
            upd_q.push_back({m_d, m_dp});
            m_dirty = 1'b0;
        end
        #50 sda_m = 1'b1;
        #100;
    endtask

    // ACK-slot monitor: the slave may only pull SDA in an expected ACK slot.
    initial begin
        forever begin
            @(oe_ev);
            if (oe_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL oe_slot: got sample with empty queue, expected entry");
            end else begin
                check("sda_oe", {31'd0, sda_oe}, {31'd0, oe_q.pop_front()});
            end
        end
    end

    // UPDATE monitor: every pulse must match a commit predicted by the model.
    always @(negedge clk) begin
        if (rst_n && update) begin
            if (upd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL update_unexpected: got pulse D=%h DP=%h expected none", d, dp);
            end else begin
                upd_exp = upd_q.pop_front();
                check("update_d", {16'd0, d}, {16'd0, upd_exp[19:4]});
                check("update_dp", {28'd0, dp}, {28'd0, upd_exp[3:0]});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] addr;
        int nb, ending;
        model_reset();
        #50;
        check("rst_d", {16'd0, d}, 32'h0);
        check("rst_dp", {28'd0, dp}, 32'h0);
        check("rst_oe", {31'd0, sda_oe}, 32'h0);
        check("rst_upd", {31'd0, update}, 32'h0);
        #50 rst_n = 1'b1;
        #200;

        // Basic write of both digit bytes.
        i2c_start(); send_byte(8'h78); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12); i2c_stop();
        #100 check("t31_d", {16'd0, d}, 32'h1234); check("t31_dp", {28'd0, dp}, 32'h0);

        // Wrong address: ignored entirely.
        i2c_start(); send_byte(8'h7A); send_byte(8'h00); send_byte(8'h55); i2c_stop();
        #100 check("t32_d", {16'd0, d}, 32'h1234); check("t32_dp", {28'd0, dp}, 32'h0);

        // Read request: NACK.
        i2c_start(); send_byte(8'h79); i2c_stop();
        #100 check("t33_d", {16'd0, d}, 32'h1234);

        // DP write then pointer runs into invalid register 3.
        i2c_start(); send_byte(8'h78); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h77); i2c_stop();
        #100 check("t34_d", {16'd0, d}, 32'h1234); check("t34_dp", {28'd0, dp}, 32'h5);

        // Repeated START keeps the shadow and the dirty flag.
        i2c_start(); send_byte(8'h78); send_byte(8'h01); send_byte(8'hAB);
        i2c_start(); send_byte(8'h78); send_byte(8'h00); send_byte(8'hCD); i2c_stop();
        #100 check("t35_d", {16'd0, d}, 32'hABCD); check("t35_dp", {28'd0, dp}, 32'h5);

        // Reset in the middle of a data byte.
        i2c_start(); send_byte(8'h78); send_byte(8'h00); send_partial(8'hFF, 4);
        #20 rst_n = 1'b0;
        #30;
        check("t36_rst_d", {16'd0, d}, 32'h0);
        check("t36_rst_dp", {28'd0, dp}, 32'h0);
        check("t36_rst_oe", {31'd0, sda_oe}, 32'h0);
        check("t36_rst_upd", {31'd0, update}, 32'h0);
        model_reset();
        #50 rst_n = 1'b1;
        #100;
        i2c_start(); send_byte(8'h78); send_byte(8'h00); send_byte(8'h99); i2c_stop();
        #100 check("t36_d", {16'd0, d}, 32'h0099); check("t36_dp", {28'd0, dp}, 32'h0);

        // Randomized transactions against the model.
        for (int t = 0; t < 25; t++) begin
            i2c_start();
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h78;
            send_byte(addr);
            nb = $urandom_range(0, 5);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom));
            ending = $urandom_range(0, 5);
            if (ending == 0) begin
                send_partial(8'($urandom), $urandom_range(1, 7));
                i2c_stop();
            end else if (ending == 1) begin
                send_partial(8'($urandom), $urandom_range(0, 7));
            end else begin
                i2c_stop();
            end
            if (ending != 1) begin
                #100 check("rnd_d", {16'd0, d}, {16'd0, m_d});
                check("rnd_dp", {28'd0, dp}, {28'd0, m_dp});
            end
        end
        i2c_stop();
        #200 check("final_d", {16'd0, d}, {16'd0, m_d});
        check("final_dp", {28'd0, dp}, {28'd0, m_dp});
        check("upd_queue_empty", upd_q.size(), 32'd0);
        check("oe_queue_empty", oe_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
